piso_serializer: RTL and testbench

Parallel-in, serial-out bit source that sits directly upstream of the serial sequence detectors and drives their one-bit `in` input. It accepts WIDTH-bit words over a valid/ready handshake and buffers them in a small FIFO. It shifts each word out one bit per clock with no gaps between consecutive words, and drives a fixed idle level whenever no word is available. The detectors sample every clock and have no qualifier, so `ser_active` is provided for checkers and scoreboards only.

---
 rtl/piso_pkg.sv | 26 ++
 rtl/sync_fifo.sv | 59 +++++
 rtl/piso_serializer.sv | 130 +++++++++++++
 tb/tb_piso_serializer.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared types and width helpers for the PISO serializer
package piso_pkg;

  typedef enum logic {
    PISO_IDLE  = 1'b0,
    PISO_SHIFT = 1'b1
  } piso_state_t;

  localparam int PISO_DEF_WIDTH = 8;
  localparam int PISO_DEF_DEPTH = 4;
  localparam int PISO_DEF_PTR_W = $clog2(PISO_DEF_DEPTH);
  localparam int PISO_DEF_FILL_W = $clog2(PISO_DEF_DEPTH + 1);

  function automatic int piso_ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int piso_fill_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int piso_cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous word FIFO with occupancy counter
module sync_fifo
  import piso_pkg::*;
#(
  parameter int WIDTH = PISO_DEF_WIDTH,
  parameter int DEPTH = PISO_DEF_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_data,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_data,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_fill
);

  localparam int PTR_W  = piso_ptr_w(DEPTH);
  localparam int FILL_W = piso_fill_w(DEPTH);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [FILL_W-1:0] r_fill;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_full    = (r_fill == FILL_W'(DEPTH));
  assign o_empty   = (r_fill == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rptr];
  assign o_fill    = r_fill;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  // Occupancy is tracked separately so full and empty never alias when pointers match.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fill <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_fill <= r_fill + 1'b1;
        2'b01:   r_fill <= r_fill - 1'b1;
        default: r_fill <= r_fill;
      endcase
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - FIFO-buffered parallel-in serial-out bit source
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = PISO_DEF_WIDTH,
  parameter int DEPTH     = PISO_DEF_DEPTH,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       ser_out,
  output logic                       ser_active,
  output logic                       frame_start,
  output logic [$clog2(DEPTH+1)-1:0] fill
);

  localparam int CNT_W = piso_cnt_w(WIDTH);

  piso_state_t      r_state;
  piso_state_t      w_state_next;
  logic [WIDTH-1:0] r_shreg;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ser_out;
  logic             r_ser_active;
  logic             r_frame_start;

  logic [WIDTH-1:0] w_fifo_data;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_load;
  logic             w_shift;
  logic             w_last;
  logic             w_cur_bit;
  logic [WIDTH-1:0] w_shifted;

  assign in_ready = !w_full && !reset;
  assign w_push   = in_valid && in_ready;
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

  assign w_cur_bit = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];
  assign w_shifted = MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0} : {1'b0, r_shreg[WIDTH-1:1]};

  sync_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .i_push (w_push),
    .i_data (in_data),
    .i_pop  (w_pop),
    .o_data (w_fifo_data),
    .o_full (w_full),
    .o_empty(w_empty),
    .o_fill (fill)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= PISO_IDLE;
    else       r_state <= w_state_next;
  end

  // Reloading on the last bit keeps consecutive words gap-free.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    case (r_state)
      PISO_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_load       = 1'b1;
          w_state_next = PISO_SHIFT;
        end
      end
      PISO_SHIFT: begin
        if (!w_last) begin
          w_shift = 1'b1;
        end else if (!w_empty) begin
          w_pop  = 1'b1;
          w_load = 1'b1;
        end else begin
          w_state_next = PISO_IDLE;
        end
      end
      default: w_state_next = PISO_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shreg <= '0;
      r_cnt   <= '0;
    end else if (w_load) begin
      r_shreg <= w_fifo_data;
      r_cnt   <= '0;
    end else if (w_shift) begin
      r_shreg <= w_shifted;
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ser_out     <= IDLE_BIT;
      r_ser_active  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (r_state == PISO_SHIFT) begin
      r_ser_out     <= w_cur_bit;
      r_ser_active  <= 1'b1;
      r_frame_start <= (r_cnt == '0);
    end else begin
      r_ser_out     <= IDLE_BIT;
      r_ser_active  <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end

  assign ser_out     = r_ser_out;
  assign ser_active  = r_ser_active;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - directed self-checking bench for piso_serializer
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       ser_out;
  logic       ser_active;
  logic       frame_start;
  logic [2:0] fill;

  logic [7:0] l_in_data = 8'h00;
  logic       l_in_valid = 1'b0;
  logic       l_in_ready;
  logic       l_ser_out;
  logic       l_ser_active;
  logic       l_frame_start;
  logic [2:0] l_fill;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .ser_out(ser_out), .ser_active(ser_active), .frame_start(frame_start), .fill(fill)
  );

  piso_serializer #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .in_data(l_in_data), .in_valid(l_in_valid), .in_ready(l_in_ready),
    .ser_out(l_ser_out), .ser_active(l_ser_active), .frame_start(l_frame_start), .fill(l_fill)
  );

  task automatic push_word(input logic [7:0] d);
    int n;
    n = 0;
    in_data = d;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL push_timeout word=%h in_ready=%b required 1", d, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    in_valid = 1'b1;
    in_data = 8'hAA;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({ser_out, ser_active, frame_start, fill, in_ready} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_state got=%b required 0000000", {ser_out, ser_active, frame_start, fill, in_ready});
    end
    reset = 1'b0;
    in_valid = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, fill} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_release in_ready,fill=%b required 1000", {in_ready, fill});
    end
    @(negedge clk);
  endtask

  task automatic test_single_word();
    logic [7:0] w;
    w = 8'hCC;
    push_word(w);
    @(negedge clk);
    n_checks++;
    if ({ser_out, ser_active} !== 2'b00) begin
      n_fail++;
      $display("FAIL single_latency got=%b required 00", {ser_out, ser_active});
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_checks++;
      if ({ser_out, ser_active, frame_start} !== {w[7-i], 1'b1, (i == 0)}) begin
        n_fail++;
        $display("FAIL single_bit%0d out,act,fs=%b required %b", i,
                 {ser_out, ser_active, frame_start}, {w[7-i], 1'b1, (i == 0)});
      end
    end
    @(negedge clk);
    n_checks++;
    if ({ser_out, ser_active, frame_start} !== 3'b000) begin
      n_fail++;
      $display("FAIL single_tail got=%b required 000", {ser_out, ser_active, frame_start});
    end
  endtask

  task automatic test_back_to_back();
    logic [47:0] stream;
    logic [7:0]  words [6];
    logic [2:0]  max_fill;
    int idx, bit_bad, gap, rdy_bad;
    stream = 48'hC0_0C_FF_00_A5_3C;
    for (int k = 0; k < 6; k++) words[k] = stream[47-8*k -: 8];
    max_fill = 3'd0;
    idx = 0; bit_bad = 0; gap = 0; rdy_bad = 0;
    fork
      begin
        for (int k = 0; k < 6; k++) push_word(words[k]);
      end
      begin
        for (int c = 0; c < 120; c++) begin
          @(negedge clk);
          if (in_ready !== (fill != 3'd4)) rdy_bad++;
          if (fill > max_fill) max_fill = fill;
          if (ser_active) begin
            if (idx < 48) begin
              if ({ser_out, frame_start} !== {stream[47-idx], (idx % 8 == 0)}) bit_bad++;
            end
            idx++;
          end else if (idx > 0 && idx < 48) begin
            gap++;
          end
        end
      end
    join
    n_checks++;
    if (idx !== 48) begin
      n_fail++;
      $display("FAIL b2b_bit_count got=%0d required 48", idx);
    end
    n_checks++;
    if (bit_bad !== 0) begin
      n_fail++;
      $display("FAIL b2b_bits wrong_bits=%0d required 0", bit_bad);
    end
    n_checks++;
    if (gap !== 0) begin
      n_fail++;
      $display("FAIL b2b_gap idle_cycles=%0d required 0", gap);
    end
    n_checks++;
    if (rdy_bad !== 0) begin
      n_fail++;
      $display("FAIL b2b_in_ready bad_cycles=%0d required 0", rdy_bad);
    end
    n_checks++;
    if (max_fill !== 3'd4) begin
      n_fail++;
      $display("FAIL b2b_max_fill got=%0d required 4", max_fill);
    end
  endtask

  task automatic test_idle_gap();
    logic [7:0] w;
    int bad;
    w = 8'hF0;
    for (int pass = 0; pass < 2; pass++) begin
      push_word(w);
      @(negedge clk);
      n_checks++;
      if ({ser_out, ser_active} !== 2'b00) begin
        n_fail++;
        $display("FAIL gap_latency%0d got=%b required 00", pass, {ser_out, ser_active});
      end
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        n_checks++;
        if ({ser_out, ser_active, frame_start} !== {w[7-i], 1'b1, (i == 0)}) begin
          n_fail++;
          $display("FAIL gap_word%0d_bit%0d got=%b required %b", pass, i,
                   {ser_out, ser_active, frame_start}, {w[7-i], 1'b1, (i == 0)});
        end
      end
      if (pass == 0) begin
        bad = 0;
        for (int i = 0; i < 11; i++) begin
          @(negedge clk);
          if ({ser_out, ser_active} !== 2'b00) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
          n_fail++;
          $display("FAIL gap_idle nonidle_cycles=%0d required 0", bad);
        end
      end
      w = 8'h0F;
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] w;
    int bad;
    w = 8'hCC;
    push_word(w);
    push_word(8'h33);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({ser_out, ser_active} !== {w[7-i], 1'b1}) begin
        n_fail++;
        $display("FAIL rst_pre_bit%0d got=%b required %b", i, {ser_out, ser_active}, {w[7-i], 1'b1});
      end
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({ser_out, ser_active, frame_start, fill, in_ready} !== 7'b0) begin
      n_fail++;
      $display("FAIL rst_mid_state got=%b required 0000000", {ser_out, ser_active, frame_start, fill, in_ready});
    end
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ({ser_out, ser_active} !== 2'b00) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL rst_no_residue active_cycles=%0d required 0", bad);
    end
    push_word(w);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_checks++;
      if ({ser_out, ser_active, frame_start} !== {w[7-i], 1'b1, (i == 0)}) begin
        n_fail++;
        $display("FAIL rst_after_bit%0d got=%b required %b", i,
                 {ser_out, ser_active, frame_start}, {w[7-i], 1'b1, (i == 0)});
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_lsb_first();
    logic [7:0] w;
    int n;
    w = 8'h03;
    n = 0;
    l_in_data = w;
    l_in_valid = 1'b1;
    while (!l_in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    l_in_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_checks++;
      if ({l_ser_out, l_ser_active, l_frame_start} !== {w[i], 1'b1, (i == 0)}) begin
        n_fail++;
        $display("FAIL lsb_bit%0d got=%b required %b", i,
                 {l_ser_out, l_ser_active, l_frame_start}, {w[i], 1'b1, (i == 0)});
      end
    end
    @(negedge clk);
    n_checks++;
    if ({l_ser_out, l_ser_active} !== 2'b00) begin
      n_fail++;
      $display("FAIL lsb_tail got=%b required 00", {l_ser_out, l_ser_active});
    end
  endtask

  task automatic test_full_boundary();
    logic [7:0] last_byte;
    int frames, nbits;
    push_word(8'h81);
    push_word(8'h12);
    push_word(8'h34);
    push_word(8'h56);
    push_word(8'h78);
    in_data = 8'h9A;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if ({in_ready, fill} !== 4'b0100) begin
        n_fail++;
        $display("FAIL full_hold%0d in_ready,fill=%b required 0100", k, {in_ready, fill});
      end
      @(negedge clk);
    end
    n_checks++;
    if ({in_ready, fill} !== 4'b1011) begin
      n_fail++;
      $display("FAIL full_after_pop in_ready,fill=%b required 1011", {in_ready, fill});
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (fill !== 3'd4) begin
      n_fail++;
      $display("FAIL full_accept fill=%0d required 4", fill);
    end
    frames = 0;
    nbits = 0;
    last_byte = 8'h00;
    for (int c = 0; c < 100; c++) begin
      if (!ser_active) break;
      if (frame_start) frames++;
      last_byte = {last_byte[6:0], ser_out};
      nbits++;
      @(negedge clk);
    end
    n_checks++;
    if (frames !== 5 || nbits !== 40) begin
      n_fail++;
      $display("FAIL full_drain frames=%0d bits=%0d required 5 40", frames, nbits);
    end
    n_checks++;
    if (last_byte !== 8'h9A) begin
      n_fail++;
      $display("FAIL full_last_word got=%h required 9a", last_byte);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_word();
    repeat (3) @(negedge clk);
    test_back_to_back();
    repeat (3) @(negedge clk);
    test_idle_gap();
    test_reset_mid_word();
    test_lsb_first();
    repeat (3) @(negedge clk);
    test_full_boundary();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
